// File: rtl/ec1_prog_loader.sv
// rtl/ec1_prog_loader.sv - framed byte-stream loader into EC1 program RAM; holds the CPU until a frame checks good.
// Define EC1_LOADER_HALT_PAD_EN to fill words beyond the program with HALT before release.
module ec1_prog_loader #(
  parameter int                ADDR_W    = 5,
  parameter int                DATA_W    = 8,
  parameter logic [7:0]        SYNC_BYTE = 8'hA5,
  parameter logic [DATA_W-1:0] HALT_WORD = 8'hE0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [2:0]        state_o
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef EC1_LOADER_HALT_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    LEN  = 3'b001,
    DATA = 3'b010,
    CSUM = 3'b011,
    PAD  = 3'b100,
    RUN  = 3'b101,
    ERR  = 3'b110
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   cnt_next;
  logic [7:0]        sum;
  logic [7:0]        sum_next;
  logic              xfer;
  logic              len_bad;

  assign state_o  = state;
  assign in_ready = !reload && (state == IDLE || state == LEN || state == DATA || state == CSUM);
  assign xfer     = in_valid && in_ready;
  assign sum_next = sum + in_data;
  assign cnt_next = cnt + 1'b1;
  assign len_bad  = (in_data == 8'd0) || (int'(in_data) > DEPTH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      addr      <= '0;
      len       <= '0;
      cnt       <= '0;
      sum       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (reload) begin
        state    <= IDLE;
        cpu_hold <= 1'b1;
        done     <= 1'b0;
        err      <= 1'b0;
      end else begin
        case (state)
          IDLE: if (xfer && in_data == SYNC_BYTE) state <= LEN;
          LEN: if (xfer) begin
            if (len_bad) begin
              state <= ERR;
              err   <= 1'b1;
            end else begin
              len   <= (ADDR_W + 1)'(in_data);
              addr  <= '0;
              cnt   <= '0;
              sum   <= '0;
              state <= DATA;
            end
          end
          DATA: if (xfer) begin
            mem_we    <= 1'b1;
            mem_addr  <= addr;
            mem_wdata <= DATA_W'(in_data);
            sum       <= sum_next;
            addr      <= addr + 1'b1;
            cnt       <= cnt_next;
            if (cnt_next == len) state <= CSUM;
          end
          CSUM: if (xfer) begin
            // addr already equals L here, so padding starts right after the program
            if (sum_next == 8'd0) begin
              if (PAD_EN && !len[ADDR_W]) begin
                state <= PAD;
              end else begin
                state    <= RUN;
                cpu_hold <= 1'b0;
                done     <= 1'b1;
              end
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
          PAD: begin
            if (PAD_EN) begin
              mem_we    <= 1'b1;
              mem_addr  <= addr;
              mem_wdata <= HALT_WORD;
              addr      <= addr + 1'b1;
              if (addr == '1) begin
                state    <= RUN;
                cpu_hold <= 1'b0;
                done     <= 1'b1;
              end
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
          RUN: state <= RUN;
          ERR: state <= ERR;
          default: begin
            state    <= ERR;
            err      <= 1'b1;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ec1_prog_loader.sv
// tb/tb_ec1_prog_loader.sv - directed frame bench for ec1_prog_loader with a frame-level write model.
module tb_ec1_prog_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       reload = 1'b0;
  logic       in_ready;
  logic       mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_hold;
  logic       done;
  logic       err;
  logic [2:0] state_o;

`ifdef EC1_LOADER_HALT_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  ec1_prog_loader dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .reload(reload), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {int a; int d; int c;} wr_t;
  wr_t        wq[$];
  wr_t        cw;
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         wcnt = 0;
  int         wbase = 0;
  logic [7:0] mem_obs[32];
  logic [7:0] fb[$];
  int         fsum;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Checks every RAM write against the model's expected (addr, data, cycle) list.
  task automatic do_compare();
    if (reset) begin
      while (wq.size() > 0 && wq[0].c < cyc) begin
        chk("missed_write_addr", -1, wq[0].a);
        void'(wq.pop_front());
      end
      if (mem_we) begin
        wcnt++;
        mem_obs[mem_addr] = mem_wdata;
        if (wq.size() == 0) begin
          chk("unexpected_write_addr", int'(mem_addr), -1);
        end else begin
          cw = wq.pop_front();
          chk("write_addr", int'(mem_addr), cw.a);
          chk("write_data", int'(mem_wdata), cw.d);
          chk("write_cycle", cyc, cw.c);
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    in_valid = 1'b1;
    in_data  = b;
    #1;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  // Frame-level model: interprets the byte list by the framing rules and queues the writes it implies.
  task automatic run_frame(input logic [7:0] f[$], input bit gaps);
    int ph = 0;
    int L = 0;
    int n = 0;
    int s = 0;
    for (int i = 0; i < f.size() && ph < 4; i++) begin
      send_byte(f[i]);
      case (ph)
        0: begin
          if (f[i] == 8'hA5) ph = 1;
          chk("hunt_state", int'(state_o), (f[i] == 8'hA5) ? 1 : 0);
        end
        1: begin
          if (f[i] == 8'h00 || int'(f[i]) > 32) begin
            ph = 4;
            chk("len_reject_state", int'(state_o), 6);
            chk("len_reject_err", int'(err), 1);
          end else begin
            L = int'(f[i]); n = 0; s = 0; ph = 2;
            chk("len_ok_state", int'(state_o), 2);
          end
        end
        2: begin
          wq.push_back('{n, int'(f[i]), cyc});
          s = (s + int'(f[i])) % 256;
          n++;
          if (n == L) ph = 3;
        end
        default: begin
          ph = 4;
          if ((s + int'(f[i])) % 256 == 0) begin
            if (PAD_EN && L < 32) begin
              for (int a = L; a < 32; a++) wq.push_back('{a, 8'hE0, cyc + 1 + a - L});
              chk("pad_enter_state", int'(state_o), 4);
              chk("pad_enter_done", int'(done), 0);
            end else begin
              chk("run_state", int'(state_o), 5);
              chk("run_done", int'(done), 1);
              chk("run_hold", int'(cpu_hold), 0);
            end
          end else begin
            chk("csum_err_state", int'(state_o), 6);
            chk("csum_err_flag", int'(err), 1);
            chk("csum_err_hold", int'(cpu_hold), 1);
            chk("csum_err_done", int'(done), 0);
          end
        end
      endcase
      if (gaps) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (wq.size() > 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_pending", wq.size(), 0);
    @(negedge clk); #1;
  endtask

  task automatic do_reload();
    reload   = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    #1;
    chk("reload_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    reload   = 1'b0;
    in_valid = 1'b0;
    chk("reload_state", int'(state_o), 0);
    chk("reload_err", int'(err), 0);
    chk("reload_done", int'(done), 0);
    chk("reload_hold", int'(cpu_hold), 1);
    @(posedge clk); #1;
    chk("reload_no_consume", int'(state_o), 0);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        do_compare();
      end
    join_none

    #1 reset = 1'b0;
    #11;
    chk("rst_state", int'(state_o), 0);
    chk("rst_we", int'(mem_we), 0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_wdata", int'(mem_wdata), 0);
    chk("rst_hold", int'(cpu_hold), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_ready", int'(in_ready), 1);
    @(negedge clk);
    reset = 1'b1;
    #1;

    // garbage then good frame
    wbase = wcnt;
    fb = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h03, 8'h60, 8'hA0, 8'hC1, 8'h3F};
    run_frame(fb, 1'b0);
    drain();
    chk("good_write_count", wcnt - wbase, PAD_EN ? 32 : 3);
    chk("good_mem0", int'(mem_obs[0]), 8'h60);
    chk("good_mem1", int'(mem_obs[1]), 8'hA0);
    chk("good_mem2", int'(mem_obs[2]), 8'hC1);
    chk("good_done", int'(done), 1);
    chk("good_hold", int'(cpu_hold), 0);
    chk("good_state", int'(state_o), 5);
    chk("good_ready", int'(in_ready), 0);
    do_reload();

    // bad checksum
    wbase = wcnt;
    fb = '{8'hA5, 8'h03, 8'h60, 8'hA0, 8'hC1, 8'h40};
    run_frame(fb, 1'b0);
    drain();
    chk("bad_write_count", wcnt - wbase, 3);
    chk("bad_state", int'(state_o), 6);
    chk("bad_err", int'(err), 1);
    chk("bad_ready", int'(in_ready), 0);
    do_reload();

    // length bounds
    wbase = wcnt;
    fb = '{8'hA5, 8'h00};
    run_frame(fb, 1'b0);
    drain();
    chk("len0_write_count", wcnt - wbase, 0);
    chk("len0_state", int'(state_o), 6);
    do_reload();
    fb = '{8'hA5, 8'h21};
    run_frame(fb, 1'b0);
    drain();
    chk("len33_write_count", wcnt - wbase, 0);
    chk("len33_state", int'(state_o), 6);
    do_reload();

    // full-depth frame with in_valid toggling
    wbase = wcnt;
    fsum = 0;
    fb = '{8'hA5, 8'h20};
    for (int i = 0; i < 32; i++) begin
      fb.push_back(8'((i * 7 + 3) % 256));
      fsum = (fsum + (i * 7 + 3)) % 256;
    end
    fb.push_back(8'((256 - fsum) % 256));
    run_frame(fb, 1'b1);
    drain();
    chk("full_write_count", wcnt - wbase, 32);
    chk("full_mem0", int'(mem_obs[0]), 8'h03);
    chk("full_mem31", int'(mem_obs[31]), 8'hDC);
    chk("full_done", int'(done), 1);
    chk("full_state", int'(state_o), 5);
    do_reload();

    // asynchronous reset mid-frame
    wbase = wcnt;
    fb = '{8'hA5, 8'h03, 8'h60, 8'hA0};
    run_frame(fb, 1'b0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_state", int'(state_o), 0);
    chk("midrst_we", int'(mem_we), 0);
    chk("midrst_hold", int'(cpu_hold), 1);
    chk("midrst_write_count", wcnt - wbase, 2);
    wq.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    wbase = wcnt;
    fb = '{8'hA5, 8'h03, 8'h60, 8'hA0, 8'hC1, 8'h3F};
    run_frame(fb, 1'b0);
    drain();
    chk("after_rst_write_count", wcnt - wbase, PAD_EN ? 32 : 3);
    chk("after_rst_mem2", int'(mem_obs[2]), 8'hC1);
    chk("after_rst_done", int'(done), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
